// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, MEM-stage redirects,
// memory wait states and halt draining. Optional stall counter enabled by STALL_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_W      = 3,
    parameter int LU_BUBBLES = 1,
    parameter int HALT_DRAIN = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_v,
    input  logic             id_rt_v,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             ex_regwrt,
    input  logic             mem_redirect,
    input  logic             mem_halt,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (LU_BUBBLES < 1 || LU_BUBBLES > 7) begin : g_bad_lu_bubbles
        $error("LU_BUBBLES must be 1..7");
    end
    if (HALT_DRAIN < 0 || HALT_DRAIN > 7) begin : g_bad_halt_drain
        $error("HALT_DRAIN must be 0..7");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        DRAIN,
        HALTED
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] lcnt, lcnt_nxt;
    logic [2:0] dcnt, dcnt_nxt;
    logic       load_use;

    assign load_use = ex_memread & ex_regwrt &
                      ((id_rs_v & (id_rs == ex_rd)) | (id_rt_v & (id_rt == ex_rd)));

    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
        state_nxt    = state;
        lcnt_nxt     = lcnt;
        dcnt_nxt     = dcnt;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        halted       = 1'b0;

        if (state == HALTED) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '0;
            halted = 1'b1;
        end else if (dmem_stall) begin
            // Freeze everything; a pending redirect/halt stays parked in EX/MEM.
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '0;
        end else if (state == DRAIN) begin
            pc_we = 1'b0;
            {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
            dcnt_nxt = dcnt - 3'd1;
            if (dcnt == 3'd1) state_nxt = HALTED;
        end else if (mem_halt) begin
            pc_we = 1'b0;
            {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
            lcnt_nxt = '0;
            dcnt_nxt = 3'(HALT_DRAIN);
            state_nxt = (HALT_DRAIN == 0) ? HALTED : DRAIN;
        end else if (mem_redirect) begin
            {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
            lcnt_nxt  = '0;
            state_nxt = RUN;
        end else if (state == LU_STALL || load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
            if (state == LU_STALL) begin
                lcnt_nxt = lcnt - 3'd1;
                if (lcnt == 3'd1) state_nxt = RUN;
            end else begin
                lcnt_nxt = 3'(LU_BUBBLES - 1);
                if (LU_BUBBLES > 1) state_nxt = LU_STALL;
            end
        end else if (imem_stall) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
        end

        // Reset forces NOPs into every latch without waiting for a clock.
        if (!rst_n) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '0;
            {if_id_flush, id_ex_flush, ex_mem_flush} = '1;
            halted = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            lcnt  <= '0;
            dcnt  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state == RUN || state == LU_STALL) && !pc_we && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes model predictions, monitor compares
// at the falling edge. Stall counter checks apply when STALL_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int REG_W      = 3;
    localparam int LU_BUBBLES = 3;
    localparam int HALT_DRAIN = 2;
    localparam int CNT_W      = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_rs_v = 1'b0, id_rt_v = 1'b0, ex_memread = 1'b0, ex_regwrt = 1'b0;
    logic mem_redirect = 1'b0, mem_halt = 1'b0, imem_stall = 1'b0, dmem_stall = 1'b0;
    logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_flush, id_ex_flush, ex_mem_flush, halted;
`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W(REG_W), .LU_BUBBLES(LU_BUBBLES), .HALT_DRAIN(HALT_DRAIN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_v(id_rs_v), .id_rt_v(id_rt_v),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrt(ex_regwrt),
        .mem_redirect(mem_redirect), .mem_halt(mem_halt),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .halted(halted)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct packed {
        logic [REG_W-1:0] rs, rt, rd;
        logic rs_v, rt_v, memread, regwrt, redirect, halt, imem, dmem, rst_n;
    } stim_t;

    // we = {pc, if_id, id_ex, ex_mem, mem_wb}; flush = {if_id, id_ex, ex_mem}
    typedef struct {
        logic [4:0] we;
        logic [2:0] flush;
        logic       halted;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: remaining bubbles / drain cycles, a halted flag, and the stall tally.
    bit m_hlt = 0, n_hlt = 0;
    int m_drain = 0, n_drain = 0, m_lu = 0, n_lu = 0, m_cnt = 0, n_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    // ld r3 in EX; add r1,r3,r2 in ID
    function automatic stim_t ld_use();
        stim_t s = idle();
        s.rd = 3'd3; s.memread = 1'b1; s.regwrt = 1'b1;
        s.rs = 3'd3; s.rs_v = 1'b1; s.rt = 3'd2; s.rt_v = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rs       = REG_W'($urandom_range(0, 7));
        s.rt       = REG_W'($urandom_range(0, 7));
        s.rd       = REG_W'($urandom_range(0, 7));
        s.rs_v     = 1'($urandom_range(0, 1));
        s.rt_v     = 1'($urandom_range(0, 1));
        s.memread  = ($urandom_range(0, 2) == 0);
        s.regwrt   = ($urandom_range(0, 3) != 0);
        s.redirect = ($urandom_range(0, 7) == 0);
        s.halt     = ($urandom_range(0, 59) == 0);
        s.imem     = ($urandom_range(0, 4) == 0);
        s.dmem     = ($urandom_range(0, 5) == 0);
        s.rst_n    = ($urandom_range(0, 99) != 0);
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   reads_load;
        @(posedge clk);
        m_hlt = n_hlt; m_drain = n_drain; m_lu = n_lu; m_cnt = n_cnt;
        #1;
        id_rs = s.rs; id_rt = s.rt; ex_rd = s.rd; id_rs_v = s.rs_v; id_rt_v = s.rt_v;
        ex_memread = s.memread; ex_regwrt = s.regwrt; mem_redirect = s.redirect;
        mem_halt = s.halt; imem_stall = s.imem; dmem_stall = s.dmem; rst_n = s.rst_n;

        e.we = 5'b11111; e.flush = 3'b000; e.halted = 1'b0;
        if (!s.rst_n) begin
            m_hlt = 0; m_drain = 0; m_lu = 0; m_cnt = 0;
            n_hlt = 0; n_drain = 0; n_lu = 0; n_cnt = 0;
            e.we = 5'b00000; e.flush = 3'b111; e.cnt = 0;
        end else begin
            n_hlt = m_hlt; n_drain = m_drain; n_lu = m_lu; n_cnt = m_cnt;
            reads_load = s.memread && s.regwrt &&
                         ((s.rs_v && s.rs == s.rd) || (s.rt_v && s.rt == s.rd));
            if (m_hlt) begin
                e.we = 5'b00000; e.halted = 1'b1;
            end else if (s.dmem) begin
                e.we = 5'b00000;
            end else if (m_drain > 0) begin
                e.we = 5'b01111; e.flush = 3'b111;
                n_drain = m_drain - 1;
                if (n_drain == 0) n_hlt = 1;
            end else if (s.halt) begin
                e.we = 5'b01111; e.flush = 3'b111; n_lu = 0;
                if (HALT_DRAIN == 0) n_hlt = 1;
                else n_drain = HALT_DRAIN;
            end else if (s.redirect) begin
                e.flush = 3'b111; n_lu = 0;
            end else if (m_lu > 0 || reads_load) begin
                e.we = 5'b00111; e.flush = 3'b010;
                n_lu = (m_lu > 0) ? m_lu - 1 : LU_BUBBLES - 1;
            end else if (s.imem) begin
                e.we = 5'b01111; e.flush = 3'b100;
            end
            if (!m_hlt && m_drain == 0 && !e.we[4] && m_cnt < (2 ** CNT_W) - 1)
                n_cnt = m_cnt + 1;
            e.cnt = m_cnt;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("we", 32'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}), 32'(e.we));
                check("flush", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'(e.flush));
                check("halted", 32'(halted), 32'(e.halted));
`ifdef STALL_CNT_EN
                check("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
`endif
            end
        end
    end

    initial begin
        stim_t s;
        // Reset held, then released into RUN.
        s = idle(); s.rst_n = 1'b0;
        repeat (2) step(s);
        s = idle();
        repeat (2) step(s);
        // Load-use hazard: LU_BUBBLES bubbles, then normal flow.
        step(ld_use());
        repeat (4) step(idle());
        // Redirect during second bubble abandons the stall.
        step(ld_use());
        s = idle(); s.redirect = 1'b1; step(s);
        repeat (2) step(idle());
        // Redirect held across a 4-cycle data stall.
        s = idle(); s.redirect = 1'b1; s.dmem = 1'b1;
        repeat (4) step(s);
        s.dmem = 1'b0; step(s);
        step(idle());
        // imem stall coinciding with hazard; then plain imem stalls.
        s = ld_use(); s.imem = 1'b1; step(s);
        s = idle(); s.imem = 1'b1; repeat (4) step(s);
        // Reset in the middle of a load-use sequence.
        step(ld_use());
        s = idle(); s.rst_n = 1'b0; step(s);
        repeat (3) step(idle());
        // Halt with simultaneous redirect, drain, then halted with ignored inputs.
        s = idle(); s.halt = 1'b1; s.redirect = 1'b1; step(s);
        repeat (3) step(idle());
        s = ld_use(); s.imem = 1'b1; s.redirect = 1'b1; step(s);
        // Reset out of HALTED, then halt and reset during drain.
        s = idle(); s.rst_n = 1'b0; step(s);
        s = idle(); s.halt = 1'b1; step(s);
        s = idle(); s.rst_n = 1'b0; step(s);
        repeat (2) step(idle());
        // Randomised episodes, each opened by a reset.
        for (int ep = 0; ep < 20; ep++) begin
            s = idle(); s.rst_n = 1'b0; step(s);
            for (int c = 0; c < 150; c++) step(rand_stim());
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
